instr_fetch: RTL and testbench

- Instruction fetch stage of the RISC-V core; sits directly upstream of the 32-entry instruction ROM and downstream of nothing but the branch/jump redirect from execute.
- Holds the PC and drives the ROM word address. Captures the combinational ROM word into an output register and hands {pc, instr} to decode over a valid/ready handshake.
- Handles redirect, halt word (0x0000007F) and out-of-range/misaligned PC fault.

---
 rtl/instr_fetch.sv | 140 ++++++++++++++
 tb/tb_instr_fetch.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: holds the PC, reads the instruction ROM and hands {pc, instr} to decode.
// Optional performance counters are built when FETCH_PERF_EN is defined; otherwise both perf ports read zero.
module instr_fetch #(
   parameter int unsigned ADDR_W     = 5,
   parameter logic [31:0] RESET_PC   = 32'h0,
   parameter logic [31:0] HALT_INSTR = 32'h0000007F
) (
   input  logic              clk,
   input  logic              rst,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [31:0]       rom_data,
   input  logic              redirect_valid,
   input  logic [31:0]       redirect_pc,
   input  logic              id_ready,
   output logic              if_valid,
   output logic [31:0]       if_instr,
   output logic [31:0]       if_pc,
   output logic              halted,
   output logic              fault,
   output logic [31:0]       perf_fetch_cnt,
   output logic [31:0]       perf_stall_cnt
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_HALT  = 2'd1,
      ST_FAULT = 2'd2
   } state_t;

   localparam logic [31:0] PC_LIMIT = 32'd4 << ADDR_W;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] ipc_q, ipc_d;
   logic        valid_q, valid_d;
   logic        fault_q, fault_d;
   logic        load;
   logic        redirect_bad;
   logic        pc_bad;

   // Handshake: the output register {if_pc, if_instr} is offered while if_valid=1 and
   // is consumed on a cycle with if_valid && id_ready; it holds while if_valid && !id_ready.
   assign load         = !valid_q || id_ready;
   assign redirect_bad = (redirect_pc[1:0] != 2'b00) || (redirect_pc >= PC_LIMIT);
   assign pc_bad       = (pc_q[1:0] != 2'b00) || (pc_q >= PC_LIMIT);

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      ipc_d   = ipc_q;
      valid_d = valid_q;
      fault_d = fault_q;
      case (state_q)
         ST_FAULT: begin
            valid_d = 1'b0;
         end
         default: begin
            if (redirect_valid) begin
               // Bad targets leave pc untouched so rom_addr stays frozen in FAULT.
               valid_d = 1'b0;
               if (redirect_bad) begin
                  state_d = ST_FAULT;
                  fault_d = 1'b1;
               end else begin
                  pc_d    = redirect_pc;
                  state_d = ST_RUN;
               end
            end else if (state_q == ST_HALT) begin
               if (id_ready) valid_d = 1'b0;
            end else if (pc_bad) begin
               state_d = ST_FAULT;
               fault_d = 1'b1;
               valid_d = 1'b0;
            end else if (load) begin
               valid_d = 1'b1;
               instr_d = rom_data;
               ipc_d   = pc_q;
               if (rom_data == HALT_INSTR) state_d = ST_HALT;
               else                        pc_d    = pc_q + 32'd4;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_RUN;
         pc_q    <= RESET_PC;
         instr_q <= 32'h0;
         ipc_q   <= 32'h0;
         valid_q <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         ipc_q   <= ipc_d;
         valid_q <= valid_d;
         fault_q <= fault_d;
      end
   end

   assign rom_addr = pc_q[ADDR_W+1:2];
   assign if_valid = valid_q;
   assign if_instr = instr_q;
   assign if_pc    = ipc_q;
   assign halted   = (state_q == ST_HALT) && !valid_q;
   assign fault    = fault_q;

`ifdef FETCH_PERF_EN
   logic [31:0] fetch_cnt_q, fetch_cnt_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      fetch_cnt_d = fetch_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (valid_q && id_ready)  fetch_cnt_d = fetch_cnt_q + 32'd1;
      if (valid_q && !id_ready) stall_cnt_d = stall_cnt_q + 32'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_cnt_q <= 32'h0;
         stall_cnt_q <= 32'h0;
      end else begin
         fetch_cnt_q <= fetch_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign perf_fetch_cnt = fetch_cnt_q;
   assign perf_stall_cnt = stall_cnt_q;
`else
   assign perf_fetch_cnt = 32'h0;
   assign perf_stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed test-plan steps with literal expectations, then randomized
// handshake/redirect/reset traffic checked every cycle against a transaction-level model.
module tb_instr_fetch;

   localparam int          DEPTH      = 32;
   localparam int          LIMIT      = 4 * DEPTH;
   localparam logic [31:0] HALT_WORD  = 32'h0000007F;
   localparam int          M_RUN      = 0;
   localparam int          M_HALT     = 1;
   localparam int          M_FAULT    = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [4:0]  rom_addr;
   logic [31:0] rom_data;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        id_ready = 1'b1;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        halted;
   logic        fault;
   logic [31:0] perf_fetch_cnt;
   logic [31:0] perf_stall_cnt;

   logic [31:0] rom [DEPTH];

   int n_vec = 0;
   int n_err = 0;

   // behavioural model state
   int          m_mode = M_RUN;
   logic [31:0] m_pc = 32'h0;
   logic        m_valid = 1'b0;
   logic [31:0] m_instr = 32'h0;
   logic [31:0] m_ipc = 32'h0;
   logic        m_fault = 1'b0;
   logic [31:0] m_fetch_cnt = 32'h0;
   logic [31:0] m_stall_cnt = 32'h0;
   logic        model_started = 1'b0;

   instr_fetch #(.ADDR_W(5), .RESET_PC(32'h0), .HALT_INSTR(32'h0000007F)) dut (
      .clk            (clk),
      .rst            (rst),
      .rom_addr       (rom_addr),
      .rom_data       (rom_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_ready       (id_ready),
      .if_valid       (if_valid),
      .if_instr       (if_instr),
      .if_pc          (if_pc),
      .halted         (halted),
      .fault          (fault),
      .perf_fetch_cnt (perf_fetch_cnt),
      .perf_stall_cnt (perf_stall_cnt)
   );

   assign rom_data = rom[rom_addr];

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: one handoff slot in front of decode, a fetch pointer, and a run/halt/fault mode.
   always @(posedge clk or posedge rst) begin
      model_started = 1'b1;
      if (rst) begin
         m_mode = M_RUN; m_pc = 32'h0; m_valid = 1'b0; m_instr = 32'h0; m_ipc = 32'h0;
         m_fault = 1'b0; m_fetch_cnt = 32'h0; m_stall_cnt = 32'h0;
      end else begin
         if (m_valid && id_ready)  m_fetch_cnt = m_fetch_cnt + 1;
         if (m_valid && !id_ready) m_stall_cnt = m_stall_cnt + 1;
         if (m_mode == M_FAULT) begin
            m_valid = 1'b0;
         end else if (redirect_valid) begin
            m_valid = 1'b0;
            if ((redirect_pc % 4) != 0 || redirect_pc >= LIMIT) begin
               m_mode = M_FAULT; m_fault = 1'b1;
            end else begin
               m_pc = redirect_pc; m_mode = M_RUN;
            end
         end else if (m_mode == M_HALT) begin
            if (m_valid && id_ready) m_valid = 1'b0;
         end else if ((m_pc % 4) != 0 || m_pc >= LIMIT) begin
            m_mode = M_FAULT; m_fault = 1'b1; m_valid = 1'b0;
         end else if (!m_valid || id_ready) begin
            m_valid = 1'b1;
            m_instr = rom[m_pc / 4];
            m_ipc   = m_pc;
            if (m_instr == HALT_WORD) m_mode = M_HALT;
            else                      m_pc = m_pc + 4;
         end
      end
   end

   always @(negedge clk) begin
      if (model_started) begin
         check("if_valid", {31'b0, if_valid}, {31'b0, m_valid});
         if (m_valid) begin
            check("if_pc", if_pc, m_ipc);
            check("if_instr", if_instr, m_instr);
         end
         check("halted", {31'b0, halted}, {31'b0, (m_mode == M_HALT) && !m_valid});
         check("fault", {31'b0, fault}, {31'b0, m_fault});
         check("rom_addr", {27'b0, rom_addr}, (m_pc >> 2) & 32'h1f);
`ifdef FETCH_PERF_EN
         check("perf_fetch_cnt", perf_fetch_cnt, m_fetch_cnt);
         check("perf_stall_cnt", perf_stall_cnt, m_stall_cnt);
`else
         check("perf_fetch_cnt", perf_fetch_cnt, 32'h0);
         check("perf_stall_cnt", perf_stall_cnt, 32'h0);
`endif
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      rom[0] = 32'h00600513;
      rom[1] = 32'h00c000ef;
      rom[2] = 32'h00a02023;
      rom[3] = HALT_WORD;
      rom[4] = 32'hff810113;
      for (int i = 5; i < DEPTH - 1; i++) begin
         rom[i] = $urandom | 32'h0000_1000;
      end
      rom[20] = HALT_WORD;
      rom[31] = 32'h0;

      // reset state
      repeat (3) tick();
      check("rst_if_valid", {31'b0, if_valid}, 32'h0);
      check("rst_fault", {31'b0, fault}, 32'h0);
      check("rst_halted", {31'b0, halted}, 32'h0);
      check("rst_rom_addr", {27'b0, rom_addr}, 32'h0);
      rst = 1'b0;

      // sequential fetch
      tick();
      check("seq0_pc", if_pc, 32'h0);
      check("seq0_instr", if_instr, 32'h00600513);
      tick();
      check("seq1_pc", if_pc, 32'h4);
      check("seq1_instr", if_instr, 32'h00c000ef);

      // stall hold
      id_ready = 1'b0;
      repeat (3) tick();
      check("stall_instr", if_instr, 32'h00c000ef);
      check("stall_pc", if_pc, 32'h4);
      check("stall_rom_addr", {27'b0, rom_addr}, 32'h2);
`ifdef FETCH_PERF_EN
      check("stall_cnt", perf_stall_cnt, 32'd3);
`endif

      // redirect flush while stalled
      redirect_valid = 1'b1; redirect_pc = 32'h10;
      tick();
      check("flush_valid", {31'b0, if_valid}, 32'h0);
      redirect_valid = 1'b0; id_ready = 1'b1;
      tick();
      check("redir_valid", {31'b0, if_valid}, 32'h1);
      check("redir_pc", if_pc, 32'h10);
      check("redir_instr", if_instr, 32'hff810113);

      // halt
      redirect_valid = 1'b1; redirect_pc = 32'h0C;
      tick();
      redirect_valid = 1'b0;
      tick();
      check("halt_instr", if_instr, HALT_WORD);
      check("halt_pc", if_pc, 32'h0C);
      tick();
      check("halted", {31'b0, halted}, 32'h1);
      check("halt_rom_addr", {27'b0, rom_addr}, 32'h3);
      tick();
      check("halted_hold", {31'b0, halted}, 32'h1);
      redirect_valid = 1'b1; redirect_pc = 32'h0;
      tick();
      check("resume_halted", {31'b0, halted}, 32'h0);
      redirect_valid = 1'b0;
      tick();
      check("resume_pc", if_pc, 32'h0);
      check("resume_valid", {31'b0, if_valid}, 32'h1);

      // misaligned redirect fault
      redirect_valid = 1'b1; redirect_pc = 32'h06;
      tick();
      check("fault_set", {31'b0, fault}, 32'h1);
      check("fault_valid", {31'b0, if_valid}, 32'h0);
      check("fault_rom_addr", {27'b0, rom_addr}, 32'h1);
      redirect_pc = 32'h0;
      tick();
      check("fault_ignore", {31'b0, fault}, 32'h1);
      check("fault_ignore_valid", {31'b0, if_valid}, 32'h0);
      check("fault_frozen_addr", {27'b0, rom_addr}, 32'h1);
      redirect_valid = 1'b0;
      rst = 1'b1;
      tick();
      check("fault_cleared", {31'b0, fault}, 32'h0);
      rst = 1'b0;

      // sequential wrap
      redirect_valid = 1'b1; redirect_pc = 32'h7C;
      tick();
      redirect_valid = 1'b0;
      tick();
      check("wrap_pc", if_pc, 32'h7C);
      check("wrap_instr", if_instr, 32'h0);
      check("wrap_no_fault", {31'b0, fault}, 32'h0);
      tick();
      check("wrap_fault", {31'b0, fault}, 32'h1);
      check("wrap_valid", {31'b0, if_valid}, 32'h0);
      rst = 1'b1;
      tick();
      rst = 1'b0;

      // randomized traffic
      for (int i = 0; i < 800; i++) begin
         id_ready = ($urandom_range(0, 99) < 70);
         redirect_valid = ($urandom_range(0, 99) < 10);
         if ($urandom_range(0, 99) < 4) begin
            redirect_pc = ($urandom_range(0, 1) == 1) ? (32'($urandom_range(0, 31)) * 4 + 32'd2)
                                                     : (32'd128 + 32'($urandom_range(0, 255)) * 4);
         end else begin
            redirect_pc = 32'($urandom_range(0, 31)) * 4;
         end
         rst = ($urandom_range(0, 99) < 2);
         tick();
      end
      rst = 1'b0; redirect_valid = 1'b0; id_ready = 1'b1;
      repeat (2) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
